// File: rtl/score_keeper.sv
// score_keeper: two-player BCD score sequencer with round-robin point
// arbitration, win detection and winner-digit blink enables.
// Optional feature macro: SCORE_KEEPER_BLINK_EN (winner's digits blink
// every BLINK_FRAMES frame ticks; when undefined both shows stay 1).
module score_keeper #(
    parameter int unsigned WIN_SCORE    = 10,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_l,
    input  logic       point_r,
    input  logic       restart,
    input  logic       frame_tick,
    output logic [3:0] l_tens,
    output logic [3:0] l_ones,
    output logic [3:0] r_tens,
    output logic [3:0] r_ones,
    output logic       show_l,
    output logic       show_r,
    output logic       game_over,
    output logic       winner
);

    localparam logic [0:0] ST_PLAY = 1'b0;
    localparam logic [0:0] ST_WIN  = 1'b1;

    localparam logic [3:0] WIN_TENS = 4'(WIN_SCORE / 10);
    localparam logic [3:0] WIN_ONES = 4'(WIN_SCORE % 10);
    localparam logic [7:0] WIN_BCD  = {WIN_TENS, WIN_ONES};

    // Two-digit BCD increment, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [0:0] state_q, state_d;
    logic       pend_l_q, pend_l_d;
    logic       pend_r_q, pend_r_d;
    logic       rr_q, rr_d;
    logic [3:0] l_tens_q, l_tens_d;
    logic [3:0] l_ones_q, l_ones_d;
    logic [3:0] r_tens_q, r_tens_d;
    logic [3:0] r_ones_q, r_ones_d;
    logic       show_l_q, show_l_d;
    logic       show_r_q, show_r_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;

    logic       grant_l_c;
    logic       grant_r_c;
    logic       rr_nxt_c;
    logic [7:0] l_next_c;
    logic [7:0] r_next_c;
    logic       phase_nxt_c;

`ifdef SCORE_KEEPER_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
`endif

    // Round-robin arbitration between pending points; rr flips only on a tie.
    always_comb begin
        grant_l_c = 1'b0;
        grant_r_c = 1'b0;
        rr_nxt_c  = rr_q;
        if (state_q == ST_PLAY) begin
            if (pend_l_q && pend_r_q) begin
                if (rr_q) begin
                    grant_r_c = 1'b1;
                end else begin
                    grant_l_c = 1'b1;
                end
                rr_nxt_c = ~rr_q;
            end else if (pend_l_q) begin
                grant_l_c = 1'b1;
            end else if (pend_r_q) begin
                grant_r_c = 1'b1;
            end
        end
    end

    // Incremented score candidates for whichever side is granted.
    always_comb begin
        l_next_c = bcd_inc({l_tens_q, l_ones_q});
        r_next_c = bcd_inc({r_tens_q, r_ones_q});
    end

    // Next-state logic: capture, grant/increment, win detect, restart.
    always_comb begin
        state_d     = state_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        rr_d        = rr_q;
        l_tens_d    = l_tens_q;
        l_ones_d    = l_ones_q;
        r_tens_d    = r_tens_q;
        r_ones_d    = r_ones_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        phase_nxt_c = 1'b1;
`ifdef SCORE_KEEPER_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
`endif

        if (restart) begin
            // Restart wins over everything; a coincident point is dropped.
            state_d     = ST_PLAY;
            pend_l_d    = 1'b0;
            pend_r_d    = 1'b0;
            rr_d        = 1'b0;
            l_tens_d    = 4'd0;
            l_ones_d    = 4'd0;
            r_tens_d    = 4'd0;
            r_ones_d    = 4'd0;
            game_over_d = 1'b0;
`ifdef SCORE_KEEPER_BLINK_EN
            blink_cnt_d = '0;
            phase_d     = 1'b1;
`endif
        end else if (state_q == ST_PLAY) begin
            rr_d     = rr_nxt_c;
            // A pulse in the grant cycle re-arms the flag so no point is lost.
            pend_l_d = (pend_l_q & ~grant_l_c) | point_l;
            pend_r_d = (pend_r_q & ~grant_r_c) | point_r;
            if (grant_l_c) begin
                {l_tens_d, l_ones_d} = l_next_c;
                if (l_next_c == WIN_BCD) begin
                    state_d     = ST_WIN;
                    game_over_d = 1'b1;
                    winner_d    = 1'b0;
                    pend_l_d    = 1'b0;
                    pend_r_d    = 1'b0;
`ifdef SCORE_KEEPER_BLINK_EN
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
`endif
                end
            end else if (grant_r_c) begin
                {r_tens_d, r_ones_d} = r_next_c;
                if (r_next_c == WIN_BCD) begin
                    state_d     = ST_WIN;
                    game_over_d = 1'b1;
                    winner_d    = 1'b1;
                    pend_l_d    = 1'b0;
                    pend_r_d    = 1'b0;
`ifdef SCORE_KEEPER_BLINK_EN
                    blink_cnt_d = '0;
                    phase_d     = 1'b1;
`endif
                end
            end
        end else begin
            // WIN: scores frozen, points ignored, frame ticks drive the blink.
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
`ifdef SCORE_KEEPER_BLINK_EN
            if (frame_tick) begin
                if (blink_cnt_q == CNT_LAST) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + CNT_W'(1);
                end
            end
`endif
        end

`ifdef SCORE_KEEPER_BLINK_EN
        phase_nxt_c = phase_d;
`endif
    end

    // Show enables from next-state values so they stay aligned with the digits.
    always_comb begin
        show_l_d = 1'b1;
        show_r_d = 1'b1;
        if (state_d == ST_WIN) begin
            if (winner_d) begin
                show_r_d = phase_nxt_c;
            end else begin
                show_l_d = phase_nxt_c;
            end
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PLAY;
            pend_l_q    <= 1'b0;
            pend_r_q    <= 1'b0;
            rr_q        <= 1'b0;
            l_tens_q    <= 4'd0;
            l_ones_q    <= 4'd0;
            r_tens_q    <= 4'd0;
            r_ones_q    <= 4'd0;
            show_l_q    <= 1'b1;
            show_r_q    <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            rr_q        <= rr_d;
            l_tens_q    <= l_tens_d;
            l_ones_q    <= l_ones_d;
            r_tens_q    <= r_tens_d;
            r_ones_q    <= r_ones_d;
            show_l_q    <= show_l_d;
            show_r_q    <= show_r_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

`ifdef SCORE_KEEPER_BLINK_EN
    // Blink counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    assign l_tens    = l_tens_q;
    assign l_ones    = l_ones_q;
    assign r_tens    = r_tens_q;
    assign r_ones    = r_ones_q;
    assign show_l    = show_l_q;
    assign show_r    = show_r_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table, directed corner sequences and a
// random run, all checked against an integer-score reference model.
module tb_score_keeper;

`ifdef SCORE_KEEPER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, point_l, point_r, restart, frame_tick;

    logic [3:0] a_l_tens, a_l_ones, a_r_tens, a_r_ones;
    logic       a_show_l, a_show_r, a_game_over, a_winner;
    logic [3:0] b_l_tens, b_l_ones, b_r_tens, b_r_ones;
    logic       b_show_l, b_show_r, b_game_over, b_winner;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(10), .BLINK_FRAMES(2)) u_dut_a (
        .clk(clk), .rst(rst), .point_l(point_l), .point_r(point_r),
        .restart(restart), .frame_tick(frame_tick),
        .l_tens(a_l_tens), .l_ones(a_l_ones), .r_tens(a_r_tens), .r_ones(a_r_ones),
        .show_l(a_show_l), .show_r(a_show_r), .game_over(a_game_over), .winner(a_winner)
    );

    score_keeper #(.WIN_SCORE(12), .BLINK_FRAMES(3)) u_dut_b (
        .clk(clk), .rst(rst), .point_l(point_l), .point_r(point_r),
        .restart(restart), .frame_tick(frame_tick),
        .l_tens(b_l_tens), .l_ones(b_l_ones), .r_tens(b_r_tens), .r_ones(b_r_ones),
        .show_l(b_show_l), .show_r(b_show_r), .game_over(b_game_over), .winner(b_winner)
    );

    // Reference model: plain integer scores, pending flags and a tick count.
    typedef struct {
        int sl;
        int sr;
        bit pl;
        bit pr;
        bit rr;
        bit over;
        bit win;
        int ticks;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_step(input mdl_t m, input int win_score, input bit rs,
                                      input bit rstt, input bit ptl, input bit ptr, input bit ft);
        mdl_t n = m;
        int g;
        if (rs) begin
            n = '{default: 0};
        end else if (rstt) begin
            n.sl = 0; n.sr = 0; n.pl = 0; n.pr = 0; n.rr = 0; n.over = 0; n.ticks = 0;
        end else if (!m.over) begin
            g = -1;
            if (m.pl && m.pr) begin
                g = m.rr ? 1 : 0;
                n.rr = !m.rr;
            end else if (m.pl) begin
                g = 0;
            end else if (m.pr) begin
                g = 1;
            end
            n.pl = (m.pl && g != 0) || ptl;
            n.pr = (m.pr && g != 1) || ptr;
            if (g == 0) n.sl = (m.sl >= 99) ? 99 : m.sl + 1;
            if (g == 1) n.sr = (m.sr >= 99) ? 99 : m.sr + 1;
            if ((g == 0 && n.sl == win_score) || (g == 1 && n.sr == win_score)) begin
                n.over = 1; n.win = (g == 1); n.pl = 0; n.pr = 0; n.ticks = 0;
            end
        end else if (ft) begin
            n.ticks = m.ticks + 1;
        end
        return n;
    endfunction

    function automatic logic [19:0] mdl_out(input mdl_t m, input int bf);
        logic s_l, s_r, ph;
        s_l = 1'b1;
        s_r = 1'b1;
        if (BLINK_EN && m.over) begin
            ph = (((m.ticks / bf) % 2) == 0);
            if (m.win) s_r = ph;
            else       s_l = ph;
        end
        return {4'(m.sl / 10), 4'(m.sl % 10), 4'(m.sr / 10), 4'(m.sr % 10),
                s_l, s_r, m.over, m.win};
    endfunction

    function automatic logic [19:0] out_a();
        return {a_l_tens, a_l_ones, a_r_tens, a_r_ones, a_show_l, a_show_r, a_game_over, a_winner};
    endfunction

    function automatic logic [19:0] out_b();
        return {b_l_tens, b_l_ones, b_r_tens, b_r_ones, b_show_l, b_show_r, b_game_over, b_winner};
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance models, sample #1 after the edge.
    task automatic step(input bit rs, input bit rstt, input bit ptl, input bit ptr, input bit ft);
        rst = rs; restart = rstt; point_l = ptl; point_r = ptr; frame_tick = ft;
        @(posedge clk);
        ma = mdl_step(ma, 10, rs, rstt, ptl, ptr, ft);
        mb = mdl_step(mb, 12, rs, rstt, ptl, ptr, ft);
        #1;
        chk("model_a", out_a(), mdl_out(ma, 2));
        chk("model_b", out_b(), mdl_out(mb, 3));
    endtask

    typedef struct {
        bit         pl;
        bit         pr;
        bit         rs;
        logic [7:0] el;
        logic [7:0] er;
        bit         ego;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit pl, input bit pr, input bit rs,
                                input logic [7:0] el, input logic [7:0] er, input bit ego);
        vec_t v;
        v.pl = pl; v.pr = pr; v.rs = rs; v.el = el; v.er = er; v.ego = ego;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_r;
        bit exp_show;

        // Spaced left points, then two ties (left first, then right first).
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h01, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h01, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h01, 8'h00, 0));
        tbl.push_back(mk(1, 0, 0, 8'h01, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h02, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h02, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h02, 8'h00, 0));
        tbl.push_back(mk(1, 0, 0, 8'h02, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h03, 8'h00, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h01, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h01, 8'h01, 0));
        tbl.push_back(mk(1, 1, 0, 8'h01, 8'h01, 0));
        tbl.push_back(mk(0, 0, 0, 8'h01, 8'h02, 0));
        tbl.push_back(mk(0, 0, 0, 8'h02, 8'h02, 0));

        rst = 1'b1; restart = 1'b0; point_l = 1'b0; point_r = 1'b0; frame_tick = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};

        // Reset state.
        step(1, 0, 0, 0, 0);
        chk("reset_a", out_a(), 20'h0000C);
        chk("reset_b", out_b(), 20'h0000C);
        step(0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].rs, tbl[i].pl, tbl[i].pr, 0);
            chk($sformatf("vec%0d", i), 20'({a_l_tens, a_l_ones, a_r_tens, a_r_ones, a_game_over}),
                20'({tbl[i].el, tbl[i].er, tbl[i].ego}));
        end

        // Ten back-to-back right points: dut_b (WIN 12) reaches 10 with no loss.
        step(0, 1, 0, 0, 0);
        for (int j = 1; j <= 11; j++) begin
            step(0, 0, 0, (j <= 10), 0);
            exp_r = {4'((j - 1) / 10), 4'((j - 1) % 10)};
            chk($sformatf("burst_r%0d", j), 20'({b_r_tens, b_r_ones, b_game_over}), 20'({exp_r, 1'b0}));
        end
        chk("burst_a_win", 20'({a_r_tens, a_r_ones, a_game_over, a_winner}), 20'h00043);

        // Left wins on dut_a; game_over and winner rise with the winning score.
        step(0, 1, 0, 0, 0);
        for (int j = 1; j <= 10; j++) step(0, 0, 1, 0, 0);
        chk("pre_win", 20'({a_l_tens, a_l_ones, a_game_over}), 20'({8'h09, 1'b0}));
        step(0, 0, 0, 0, 0);
        chk("win_edge", 20'({a_l_tens, a_l_ones, a_game_over, a_winner}), 20'({8'h10, 2'b10}));
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("win_ignore_r", 20'({a_r_tens, a_r_ones, a_l_tens, a_l_ones}), 20'h00010);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 0, 1);
            exp_show = BLINK_EN ? (((k / 2) % 2) == 0) : 1'b1;
            chk($sformatf("blink%0d", k), 20'({a_show_l, a_show_r}), 20'({exp_show, 1'b1}));
            step(0, 0, 0, 0, 0);
        end

        // Restart in WIN with a coincident left point: point dropped.
        step(0, 1, 1, 0, 0);
        chk("restart_win", out_a(), 20'h0000C);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("after_restart", 20'({a_l_tens, a_l_ones, a_r_tens, a_r_ones, a_game_over}), 20'h00002);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 255) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
